// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, baud-generator state type and divisor math.
// Divisors are evaluated at elaboration time only; no run-time dividers are built.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int unsigned RATE_9600   = 9600;
    localparam int unsigned RATE_19200  = 19200;
    localparam int unsigned RATE_38400  = 38400;
    localparam int unsigned RATE_57600  = 57600;
    localparam int unsigned RATE_115200 = 115200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } baud_state_t;

    typedef struct packed {
        int unsigned div;
        int unsigned half;
        int unsigned os_div;
    } baud_div_t;

    // Bit divisor rounds to nearest so the long-run rate error stays minimal;
    // the oversample divisor floors so 16 strobes always fit inside one bit.
    function automatic baud_div_t calc_div(input int unsigned clk_hz, input int unsigned baud);
        baud_div_t d;
        d.div    = (clk_hz + baud / 2) / baud - 1;
        d.half   = d.div / 2;
        d.os_div = clk_hz / (16 * baud) - 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_lut.sv
// uart_baud_lut: combinational baud_sel -> {div, half, os_div} lookup.
// The os_div port exists only when UART_BAUD_OS_EN is defined.
module uart_baud_lut
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 16
) (
    input  logic [2:0]       baud_sel,
`ifdef UART_BAUD_OS_EN
    output logic [CNT_W-1:0] os_div,
`endif
    output logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] half
);

    localparam baud_div_t D0 = calc_div(CLK_HZ, RATE_9600);
    localparam baud_div_t D1 = calc_div(CLK_HZ, RATE_19200);
    localparam baud_div_t D2 = calc_div(CLK_HZ, RATE_38400);
    localparam baud_div_t D3 = calc_div(CLK_HZ, RATE_57600);
    localparam baud_div_t D4 = calc_div(CLK_HZ, RATE_115200);

    // Codes 5..7 fall through to the 9600 default.
    always_comb begin
        div  = CNT_W'(D0.div);
        half = CNT_W'(D0.half);
        case (baud_sel)
            BAUD_19200: begin
                div  = CNT_W'(D1.div);
                half = CNT_W'(D1.half);
            end
            BAUD_38400: begin
                div  = CNT_W'(D2.div);
                half = CNT_W'(D2.half);
            end
            BAUD_57600: begin
                div  = CNT_W'(D3.div);
                half = CNT_W'(D3.half);
            end
            BAUD_115200: begin
                div  = CNT_W'(D4.div);
                half = CNT_W'(D4.half);
            end
            default: ;
        endcase
    end

`ifdef UART_BAUD_OS_EN
    always_comb begin
        os_div = CNT_W'(D0.os_div);
        case (baud_sel)
            BAUD_19200:  os_div = CNT_W'(D1.os_div);
            BAUD_38400:  os_div = CNT_W'(D2.os_div);
            BAUD_57600:  os_div = CNT_W'(D3.os_div);
            BAUD_115200: os_div = CNT_W'(D4.os_div);
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: run-time selectable baud tick generator with bit/frame tracking.
// Optional 16x oversample strobe is built when UART_BAUD_OS_EN is defined.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int          CNT_W      = 16,
    parameter int          FRAME_BITS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bps_start,
    input  logic [2:0] baud_sel,
    output logic       busy,
    output logic       tick_mid,
    output logic       tick_end,
    output logic       tick_os,
    output logic [3:0] bit_idx,
    output logic       frame_done
);

    // state | meaning
    // IDLE  | counters clear, waiting for bps_start; rate is latched on exit
    // RUN   | counting bit periods with the latched rate
    // DONE  | frame complete, parked until bps_start drops

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

    baud_state_t      state;
    baud_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] lut_div;
    logic [CNT_W-1:0] lut_half;
    logic             run_active;
    logic             load_rate;
    logic             cnt_wrap;
    logic             last_bit;
    logic             mid_d;
    logic             end_d;
    logic             done_d;
`ifdef UART_BAUD_OS_EN
    logic [CNT_W-1:0] lut_os;
    logic [CNT_W-1:0] os_r;
    logic [CNT_W-1:0] os_cnt;
    logic             os_hit;
    logic             tick_os_r;
`endif

    uart_baud_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_lut (
        .baud_sel (baud_sel),
`ifdef UART_BAUD_OS_EN
        .os_div   (lut_os),
`endif
        .div      (lut_div),
        .half     (lut_half)
    );

    assign cnt_wrap = (cnt == div_r);
    assign last_bit = (bit_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bps_start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!bps_start) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_wrap && last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: if (!bps_start) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Abort wins: a low bps_start in RUN suppresses every strobe on that edge.
    always_comb begin
        busy       = (state != ST_IDLE);
        load_rate  = (state == ST_IDLE) && bps_start;
        run_active = (state == ST_RUN) && bps_start;
        mid_d      = run_active && (cnt == half_r);
        end_d      = run_active && cnt_wrap;
        done_d     = end_d && last_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            div_r      <= '0;
            half_r     <= '0;
            tick_mid   <= 1'b0;
            tick_end   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_mid   <= mid_d;
            tick_end   <= end_d;
            frame_done <= done_d;
            if (load_rate) begin
                div_r  <= lut_div;
                half_r <= lut_half;
            end
            if (run_active) begin
                if (cnt_wrap) begin
                    cnt     <= '0;
                    bit_idx <= last_bit ? 4'd0 : bit_idx + 4'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt     <= '0;
                bit_idx <= '0;
            end
        end
    end

`ifdef UART_BAUD_OS_EN
    assign os_hit = (os_cnt == os_r);

    // Clearing on every bit wrap keeps the oversample phase locked to bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_r      <= '0;
            os_cnt    <= '0;
            tick_os_r <= 1'b0;
        end else begin
            if (load_rate) begin
                os_r <= lut_os;
            end
            tick_os_r <= run_active && os_hit;
            if (!run_active || cnt_wrap || os_hit) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + CNT_W'(1);
            end
        end
    end

    assign tick_os = tick_os_r;
`else
    assign tick_os = 1'b0;
`endif

endmodule
